// File: rtl/csse232_project_3_bit_mux_pkg.sv
// Shared constants for the five-input word multiplexer: default width,
// select encodings and the legality helper used by the mux and its wrapper.
package csse232_project_3_bit_mux_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [2:0] {
    SEL_A = 3'd0,
    SEL_B = 3'd1,
    SEL_C = 3'd2,
    SEL_D = 3'd3,
    SEL_E = 3'd4
  } sel_e;

  // Highest legal select code; anything above it routes zeros and flags an error.
  localparam logic [2:0] SEL_LAST = 3'd4;

  function automatic logic sel_is_legal(input logic [2:0] sel);
    return (sel <= SEL_LAST);
  endfunction

endpackage

// File: rtl/csse232_project_3_bit_mux_if.sv
// Bundles the five source words, the select and the mux results.
// master drives sources/select; slave is the mux side producing results.
interface csse232_project_3_bit_mux_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] e;
  logic [2:0]       sel;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             sel_err;
  logic             sel_err_sticky;

  modport master (
    output a, b, c, d, e, sel,
    input  out, out_q, sel_err, sel_err_sticky
  );

  modport slave (
    input  a, b, c, d, e, sel,
    output out, out_q, sel_err, sel_err_sticky
  );
endinterface

// File: rtl/csse232_project_3_bit_mux_mux5_comb.sv
// Pure combinational 5:1 word select with illegal-select detection.
// Illegal codes (5..7) route all zeros so the shared bus never floats.
module csse232_project_3_bit_mux_mux5_comb
  import csse232_project_3_bit_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             sel_err
);

  // Select the addressed source; zeros and an error flag for unused codes.
  always_comb begin
    out     = '0;
    sel_err = ~sel_is_legal(sel);
    case (sel)
      SEL_A:   out = a;
      SEL_B:   out = b;
      SEL_C:   out = c;
      SEL_D:   out = d;
      SEL_E:   out = e;
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/csse232_project_3_bit_mux.sv
// Accumulator-datapath source mux: combinational select for same-cycle use,
// plus a registered copy and a sticky illegal-select flag for clocked
// consumers and debug. Registers clear asynchronously on reset.
module csse232_project_3_bit_mux
  import csse232_project_3_bit_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  csse232_project_3_bit_mux_if.slave    bus
);

  logic [WIDTH-1:0] mux_out;
  logic             mux_err;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic             sticky_d;
  logic             sticky_q;

  csse232_project_3_bit_mux_mux5_comb #(
    .WIDTH (WIDTH)
  ) u_mux (
    .a       (bus.a),
    .b       (bus.b),
    .c       (bus.c),
    .d       (bus.d),
    .e       (bus.e),
    .sel     (bus.sel),
    .out     (mux_out),
    .sel_err (mux_err)
  );

  // Next-state: capture the selected word; accumulate any illegal select.
  always_comb begin
    out_d    = mux_out;
    sticky_d = sticky_q | mux_err;
  end

  // Output registers; reset clears them at once and wins over a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.out            = mux_out;
  assign bus.sel_err        = mux_err;
  assign bus.out_q          = out_q;
  assign bus.sel_err_sticky = sticky_q;

endmodule

// File: tb/tb_csse232_project_3_bit_mux.sv
// Self-checking bench: expectations are pushed to a scoreboard when stimulus
// is applied and popped against the DUT once the result should be visible.
module tb_csse232_project_3_bit_mux;

  localparam int W = 16;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  string        tag_q[$];
  logic [W-1:0] val_q[$];

  csse232_project_3_bit_mux_if #(.WIDTH(W)) bus ();

  csse232_project_3_bit_mux #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference select: index a table of the five sources, zero for codes 5..7.
  function automatic logic [W-1:0] ref_mux(input logic [2:0] s);
    logic [W-1:0] tbl [5];
    tbl[0] = bus.a; tbl[1] = bus.b; tbl[2] = bus.c; tbl[3] = bus.d; tbl[4] = bus.e;
    if (int'(s) < 5) return tbl[int'(s)];
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic sb_push(input string tag, input logic [W-1:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [W-1:0] obs);
    if (val_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL sb_empty: got %h want <entry>", obs);
    end else begin
      chk(tag_q.pop_front(), obs, val_q.pop_front());
    end
  endtask

  // Apply a select, expect the combinational result and flag.
  task automatic apply_sel(input logic [2:0] s, input string tag);
    bus.sel = s;
    sb_push({tag, "_out"}, ref_mux(s));
    sb_push({tag, "_err"}, {{(W-1){1'b0}}, (s > 3'd4)});
    #1;
    sb_pop(bus.out);
    sb_pop({{(W-1){1'b0}}, bus.sel_err});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held;
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.a = 16'h3524; bus.b = 16'h5E81; bus.c = 16'hD609;
    bus.d = 16'h5663; bus.e = 16'h7B0D; bus.sel = 3'd0;
    #2;
    chk("rst_out_q", bus.out_q, '0);
    chk("rst_sticky", {15'd0, bus.sel_err_sticky}, '0);
    @(negedge clk);
    reset = 1'b0;

    // Walk the legal selects; each result also appears on out_q after an edge.
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      apply_sel(3'(s), $sformatf("sel%0d", s));
      held = bus.out;
      sb_push($sformatf("sel%0d_q", s), ref_mux(3'(s)));
      @(posedge clk); #1;
      sb_pop(bus.out_q);
      chk($sformatf("sel%0d_sticky", s), {15'd0, bus.sel_err_sticky}, '0);
    end

    // Selected input change propagates; non-selected change does not.
    @(negedge clk);
    bus.e = 16'h998D; #1;
    chk("e_change", bus.out, 16'h998D);
    bus.a = 16'h0F0F; #1;
    chk("a_nosel", bus.out, 16'h998D);

    // Illegal selects: zeros, error flag, sticky rises on the next edge only.
    @(negedge clk);
    apply_sel(3'd5, "sel5");
    chk("sticky_pre", {15'd0, bus.sel_err_sticky}, '0);
    apply_sel(3'd6, "sel6");
    apply_sel(3'd7, "sel7");
    @(posedge clk); #1;
    chk("sticky_set", {15'd0, bus.sel_err_sticky}, 16'd1);
    @(negedge clk);
    apply_sel(3'd0, "sel0_back");
    @(posedge clk); #1;
    chk("sticky_hold", {15'd0, bus.sel_err_sticky}, 16'd1);

    // out_q takes whatever is present at the edge.
    @(negedge clk);
    bus.c = 16'hBEEF;
    apply_sel(3'd2, "selc");
    @(posedge clk); #1;
    chk("outq_beef", bus.out_q, 16'hBEEF);
    @(negedge clk);
    bus.c = 16'h1234;
    @(posedge clk); #1;
    chk("outq_late", bus.out_q, 16'h1234);
    @(negedge clk);
    bus.c = 16'hBEEF;
    @(posedge clk); #1;
    chk("outq_beef2", bus.out_q, 16'hBEEF);

    // Asynchronous reset between edges clears registers; out keeps tracking.
    #2;
    reset = 1'b1; #1;
    chk("arst_out_q", bus.out_q, '0);
    chk("arst_sticky", {15'd0, bus.sel_err_sticky}, '0);
    bus.c = 16'h4444; #1;
    chk("arst_out", bus.out, 16'h4444);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_cap", bus.out_q, 16'h4444);

    // Reset coincident with an edge while sel is illegal: sticky stays low.
    @(negedge clk);
    bus.sel = 3'd6;
    #5;
    reset = 1'b1;
    #1;
    chk("coinc_sticky", {15'd0, bus.sel_err_sticky}, '0);
    chk("coinc_out_q", bus.out_q, '0);
    @(negedge clk);
    bus.sel = 3'd0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("after_coinc_sticky", {15'd0, bus.sel_err_sticky}, '0);
    chk("after_coinc_q", bus.out_q, 16'h0F0F);

    if (val_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL sb_leftover: got %0d want 0", val_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
